// File: rtl/serial_eq.sv
// Bit-serial word equality checker: LSB-first operand pairs in, one equal/not-equal result per WIDTH bits.
// Optional mismatch-index output O_idx is enabled by defining SERIAL_EQ_MISMATCH_IDX_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for bit 0 of a new word
// SHIFT | bits 1..WIDTH-1 being accumulated
// DONE  | result presented on O/O_valid, input stalled until O_ready
module serial_eq #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic ASYNCRESET,
  input  logic I0,
  input  logic I1,
  input  logic I_valid,
  output logic I_ready,
  output logic O,
  output logic O_valid,
  input  logic O_ready
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] O_idx
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          acc;
  logic [CW-1:0] cnt;
  logic          bit_eq;
  logic          accept;

  assign bit_eq = ~(I0 ^ I1);
  assign accept = I_valid & I_ready;

  // Outputs are registered alongside the state so they change together with it.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state   <= IDLE;
      acc     <= 1'b1;
      cnt     <= '0;
      I_ready <= 1'b1;
      O_valid <= 1'b0;
      O       <= 1'b0;
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
      O_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= bit_eq;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            acc <= acc & bit_eq;
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
            // acc still high means no earlier bit mismatched
            if (acc && !bit_eq) O_idx <= cnt;
`endif
            if (cnt == LAST) begin
              state   <= DONE;
              I_ready <= 1'b0;
              O_valid <= 1'b1;
              O       <= acc & bit_eq;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (O_ready) begin
            state   <= IDLE;
            acc     <= 1'b1;
            cnt     <= '0;
            I_ready <= 1'b1;
            O_valid <= 1'b0;
            O       <= 1'b0;
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
            O_idx   <= '0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          acc     <= 1'b1;
          cnt     <= '0;
          I_ready <= 1'b1;
          O_valid <= 1'b0;
          O       <= 1'b0;
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
          O_idx   <= '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq.sv
// Directed bench for serial_eq (WIDTH=4); O_idx is checked when SERIAL_EQ_MISMATCH_IDX_EN is defined.
module tb_serial_eq;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH);

  logic CLK = 1'b0;
  logic ASYNCRESET;
  logic I0, I1, I_valid, I_ready;
  logic O, O_valid, O_ready;
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
  logic [CW-1:0] O_idx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_eq #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .I0         (I0),
    .I1         (I1),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
    .O          (O),
    .O_valid    (O_valid),
    .O_ready    (O_ready)
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
    ,
    .O_idx      (O_idx)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic vld, input logic o);
    check({tag, "_rdy"}, 32'(I_ready), 32'(rdy));
    check({tag, "_vld"}, 32'(O_valid), 32'(vld));
    check({tag, "_o"},   32'(O),       32'(o));
  endtask

  // Sends one word; optional gap of gap_len idle cycles after bit gap_at. Ends in DONE.
  task automatic send_word(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic exp_o, input int exp_idx, input int gap_at, input int gap_len);
    for (int i = 0; i < WIDTH; i++) begin
      I0 = a[i]; I1 = b[i]; I_valid = 1'b1;
      check_outs({tag, "_bit"}, 1'b1, 1'b0, 1'b0);
      tick();
      if (i == gap_at) begin
        I_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check_outs({tag, "_gap"}, 1'b1, 1'b0, 1'b0);
        end
      end
    end
    I_valid = 1'b0;
    check_outs({tag, "_done"}, 1'b0, 1'b1, exp_o);
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
    check({tag, "_idx"}, 32'(O_idx), 32'(exp_idx));
`else
    if (exp_idx < 0) $display("bad idx argument in %s", tag);
`endif
  endtask

  logic [3:0] wa [3];
  logic [3:0] wb [3];
  logic       wo [3];
  int         bubbles;

  initial begin
    ASYNCRESET = 1'b1;
    I0 = 1'b0; I1 = 1'b0; I_valid = 1'b0; O_ready = 1'b1;
    #2;
    check_outs("reset_async", 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_EQ_MISMATCH_IDX_EN
    check("reset_idx", 32'(O_idx), 32'd0);
`endif
    tick();
    tick();
    ASYNCRESET = 1'b0;
    tick();
    check_outs("reset_held", 1'b1, 1'b0, 1'b0);

    // Equal word, immediate handshake, back to IDLE
    send_word("eq_a", 4'hA, 4'hA, 1'b1, 0, -1, 0);
    tick();
    check_outs("eq_a_idle", 1'b1, 1'b0, 1'b0);

    send_word("ne_ab", 4'hA, 4'hB, 1'b0, 0, -1, 0);
    tick();
    send_word("ne_3b", 4'h3, 4'hB, 1'b0, 3, -1, 0);
    tick();

    // Two-cycle gap between bits 1 and 2
    send_word("gap_55", 4'h5, 4'h5, 1'b1, 0, 1, 2);
    tick();

    // Stall in DONE with next word's bit 0 already presented
    O_ready = 1'b0;
    send_word("stall", 4'h9, 4'h9, 1'b1, 0, -1, 0);
    I0 = 1'b1; I1 = 1'b0; I_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("stall_hold", 1'b0, 1'b1, 1'b1);
    end
    O_ready = 1'b1;
    tick();
    check_outs("stall_exit", 1'b1, 1'b0, 1'b0);
    send_word("after_stall", 4'h1, 4'h0, 1'b0, 0, -1, 0);
    tick();

    // Reset while a result is pending
    O_ready = 1'b0;
    send_word("rst_done", 4'h0, 4'hF, 1'b0, 0, -1, 0);
    #3 ASYNCRESET = 1'b1;
    #1 check_outs("rst_done_async", 1'b1, 1'b0, 1'b0);
    #1 ASYNCRESET = 1'b0;
    O_ready = 1'b1;

    // Reset mid-word after two mismatching bits
    @(posedge CLK); #1;
    I0 = 1'b0; I1 = 1'b1; I_valid = 1'b1;
    tick();
    tick();
    I_valid = 1'b0;
    #3 ASYNCRESET = 1'b1;
    #1 check_outs("rst_mid_async", 1'b1, 1'b0, 1'b0);
    #1 ASYNCRESET = 1'b0;
    send_word("post_rst_ff", 4'hF, 4'hF, 1'b1, 0, -1, 0);
    tick();

    // Three back-to-back words: 4 accept cycles plus one bubble each
    wa[0] = 4'hC; wb[0] = 4'hC; wo[0] = 1'b1;
    wa[1] = 4'h7; wb[1] = 4'h6; wo[1] = 1'b0;
    wa[2] = 4'hE; wb[2] = 4'hE; wo[2] = 1'b1;
    bubbles = 0;
    for (int c = 0; c < 15; c++) begin
      automatic int w = c / 5;
      automatic int p = c % 5;
      I_valid = 1'b1;
      if (p < WIDTH) begin
        I0 = wa[w][p]; I1 = wb[w][p];
        check("b2b_rdy", 32'(I_ready), 32'd1);
      end else begin
        if (w < 2) begin
          I0 = wa[w+1][0]; I1 = wb[w+1][0];
        end
        check_outs("b2b_result", 1'b0, 1'b1, wo[w]);
      end
      if (I_ready == 1'b0) bubbles++;
      tick();
    end
    I_valid = 1'b0;
    check("b2b_bubbles", 32'(bubbles), 32'd3);
    check_outs("b2b_idle", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
